// File: rtl/mine_pkg.sv
// Shared constants and FSM state encoding for the mine placement sequencer.
// Used by mine_place_ctrl and lcg_step.
package mine_pkg;

    localparam int GRID_CELLS = 25;
    localparam int LCG_W      = 16;
    localparam int CELL_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lcg_step.sv
// One combinational LCG step X' = a*X + c (mod 2^LCG_W), plus the mapping of X'
// onto a board cell index 0..24.
module lcg_step
    import mine_pkg::*;
(
    input  logic [LCG_W-1:0]      in_x,
    input  logic [LCG_W-1:0]      in_a,
    input  logic [LCG_W-1:0]      in_c,
    output logic [LCG_W-1:0]      out_x_next,
    output logic [CELL_IDX_W-1:0] out_cell
);

    logic [12:0] w_scaled;

    assign out_x_next = in_a * in_x + in_c;

    // Top byte scaled by 25/256 keeps the index inside the board without a divider.
    assign w_scaled = {5'd0, out_x_next[LCG_W-1 -: 8]} * 13'd25;
    assign out_cell = 5'(w_scaled >> 8);

endmodule

// File: rtl/mine_place_ctrl.sv
// Fills the 5x5 board with LCG-drawn mines, resolving collisions by linear probing.
// Optional macro MINE_SAFE_CELL_EN adds in_safe_cell, a cell that is never mined.
module mine_place_ctrl #(
    parameter int GRID_CELLS = 25,
    parameter int LCG_W      = 16,
    parameter int MAX_MINES  = 24
) (
    input  logic                  in_clka,
    input  logic                  in_rst_n,
    input  logic                  in_start,
    input  logic [LCG_W-1:0]      in_mult,
    input  logic [LCG_W-1:0]      in_increment,
    input  logic [LCG_W-1:0]      in_seed,
    input  logic [4:0]            in_mines_num,
`ifdef MINE_SAFE_CELL_EN
    input  logic [4:0]            in_safe_cell,
`endif
    output logic [GRID_CELLS-1:0] out_mines,
    output logic                  out_busy,
    output logic                  out_done
);
    import mine_pkg::*;

    // state | meaning
    // IDLE  | waiting for in_start; out_mines holds the last board
    // DRAW  | advance the LCG and take a fresh candidate cell
    // PROBE | place at candidate, or step to the next cell if occupied
    // DONE  | one-cycle done strobe with the new board on out_mines

    state_t                  r_state, w_state_next;
    logic [LCG_W-1:0]        r_a, r_c, r_x, w_x_next;
    logic [CELL_IDX_W-1:0]   r_cand, r_target, r_count;
    logic [CELL_IDX_W-1:0]   w_cell, w_target, w_cand_inc;
    logic [GRID_CELLS-1:0]   r_map, w_map_next, r_mines;
    logic                    w_accept, w_draw, w_place, w_occupied;

    lcg_step u_lcg (
        .in_x      (r_x),
        .in_a      (r_a),
        .in_c      (r_c),
        .out_x_next(w_x_next),
        .out_cell  (w_cell)
    );

    assign w_target   = (in_mines_num > 5'(MAX_MINES)) ? 5'(MAX_MINES) : in_mines_num;
    assign w_cand_inc = (r_cand == 5'(GRID_CELLS - 1)) ? '0 : r_cand + 5'd1;

`ifdef MINE_SAFE_CELL_EN
    logic [4:0] r_safe;
    // Out-of-range safe values never match a candidate, which disables the exclusion.
    assign w_occupied = r_map[r_cand] | (r_cand == r_safe);

    always_ff @(posedge in_clka or negedge in_rst_n) begin
        if (!in_rst_n)
            r_safe <= '0;
        else if (w_accept)
            r_safe <= in_safe_cell;
    end
`else
    assign w_occupied = r_map[r_cand];
`endif

    always_ff @(posedge in_clka or negedge in_rst_n) begin
        if (!in_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_draw       = 1'b0;
        w_place      = 1'b0;
        w_map_next   = r_map;
        case (r_state)
            IDLE: begin
                if (in_start) begin
                    w_accept     = 1'b1;
                    w_map_next   = '0;
                    w_state_next = (w_target == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                w_draw       = 1'b1;
                w_state_next = PROBE;
            end
            PROBE: begin
                if (!w_occupied) begin
                    w_place            = 1'b1;
                    w_map_next[r_cand] = 1'b1;
                    w_state_next       = (r_count + 5'd1 == r_target) ? DONE : DRAW;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clka or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_a      <= '0;
            r_c      <= '0;
            r_x      <= '0;
            r_target <= '0;
            r_count  <= '0;
            r_cand   <= '0;
            r_map    <= '0;
            r_mines  <= '0;
        end else begin
            r_map <= w_map_next;
            if (w_accept) begin
                r_a      <= in_mult;
                r_c      <= in_increment;
                r_x      <= in_seed;
                r_target <= w_target;
                r_count  <= '0;
            end
            if (w_draw) begin
                r_x    <= w_x_next;
                r_cand <= w_cell;
            end
            if (r_state == PROBE && w_occupied)
                r_cand <= w_cand_inc;
            if (w_place)
                r_count <= r_count + 5'd1;
            // Published board changes only when entering DONE.
            if (w_state_next == DONE && r_state != DONE)
                r_mines <= w_map_next;
        end
    end

    assign out_mines = r_mines;
    assign out_busy  = (r_state == DRAW) || (r_state == PROBE);
    assign out_done  = (r_state == DONE);

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Self-checking bench for mine_place_ctrl: scoreboard of expected boards and done latencies.
module tb_mine_place_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] mult = '0;
    logic [15:0] inc = '0;
    logic [15:0] seed = '0;
    logic [4:0]  mines_num = '0;
`ifdef MINE_SAFE_CELL_EN
    logic [4:0]  safe_cell = 5'd31;
`endif
    logic [24:0] out_mines;
    logic        out_busy;
    logic        out_done;

    typedef struct {
        logic [24:0] mines;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    mine_place_ctrl dut (
        .in_clka     (clk),
        .in_rst_n    (rst_n),
        .in_start    (start),
        .in_mult     (mult),
        .in_increment(inc),
        .in_seed     (seed),
        .in_mines_num(mines_num),
`ifdef MINE_SAFE_CELL_EN
        .in_safe_cell(safe_cell),
`endif
        .out_mines   (out_mines),
        .out_busy    (out_busy),
        .out_done    (out_done)
    );

    always #5 clk = ~clk;

    // Independent software model: map and the cycle (1-based after accept) in which done is high.
    function automatic void model_run(input logic [15:0] a, input logic [15:0] c,
                                      input logic [15:0] s, input logic [4:0] n,
                                      output logic [24:0] map, output int cyc);
        int          tgt;
        int          cand;
        logic [15:0] x;
        tgt = (n > 5'd24) ? 24 : int'(n);
        x   = s;
        map = '0;
        cyc = 1;
        for (int i = 0; i < tgt; i++) begin
            x    = a * x + c;
            cand = (int'(x[15:8]) * 25) / 256;
            cyc += 2;
            while (map[cand]) begin
                cand = (cand == 24) ? 0 : cand + 1;
                cyc++;
            end
            map[cand] = 1'b1;
        end
    endfunction

    task automatic start_run(input logic [15:0] a, input logic [15:0] c, input logic [15:0] s,
                             input logic [4:0] n, input logic [24:0] exp_m, input int exp_c);
        @(negedge clk);
        mult      = a;
        inc       = c;
        seed      = s;
        mines_num = n;
        start     = 1'b1;
        sb.push_back('{mines: exp_m, cycles: exp_c});
        @(posedge clk);
    endtask

    task automatic wait_done(input int n0, input bit hold, output int n, output bit tmo);
        n   = 0;
        tmo = 1'b1;
        for (int i = n0 + 1; i <= n0 + 3000; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (out_done === 1'b1) begin
                n   = i;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int   cyc;
        bit   tmo;
        exp_t e;
        #2;
        n_checks++; if (out_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", out_busy); else n_pass++;
        n_checks++; if (out_done !== 1'b0) $display("FAIL rst_done: got %b want 0", out_done); else n_pass++;
        n_checks++; if (out_mines !== 25'h0) $display("FAIL rst_mines: got %h want 0", out_mines); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;

        start_run(16'h0001, 16'h8000, 16'h0000, 5'd1, 25'h0001000, 3);
        wait_done(0, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || out_mines !== e.mines) $display("FAIL rst_prerun: got %h (timeout=%0b) want %h", out_mines, tmo, e.mines); else n_pass++;

        start_run(16'h0001, 16'h0000, 16'h0000, 5'd3, 25'h0000007, 10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++; if (out_busy !== 1'b1) $display("FAIL rst_midrun_busy: got %b want 1", out_busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", out_busy); else n_pass++;
        n_checks++; if (out_done !== 1'b0) $display("FAIL rst_async_done: got %b want 0", out_done); else n_pass++;
        n_checks++; if (out_mines !== 25'h0) $display("FAIL rst_async_mines: got %h want 0", out_mines); else n_pass++;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        start_run(16'h0001, 16'h8000, 16'h0000, 5'd1, 25'h0001000, 3);
        wait_done(0, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL rst_fresh_lat: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL rst_fresh_mines: got %h want %h", out_mines, e.mines); else n_pass++;
    endtask

    task automatic test_forced_collisions;
        int   cyc;
        bit   tmo;
        exp_t e;
        start_run(16'h0001, 16'h0000, 16'h0000, 5'd3, 25'h0000007, 10);
        wait_done(0, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL fc_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL fc_mines: got %h want %h", out_mines, e.mines); else n_pass++;
        n_checks++; if (out_busy !== 1'b0) $display("FAIL fc_busy_in_done: got %b want 0", out_busy); else n_pass++;
    endtask

    task automatic test_index_mapping;
        int   cyc;
        bit   tmo;
        exp_t e;
        start_run(16'h0001, 16'h8000, 16'h0000, 5'd1, 25'h0001000, 3);
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (out_busy !== 1'b1) $display("FAIL idx_busy_draw: got %b want 1", out_busy); else n_pass++;
        wait_done(1, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL idx_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL idx_mines: got %h want %h", out_mines, e.mines); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_done !== 1'b0) $display("FAIL idx_done_pulse: got %b want 0", out_done); else n_pass++;
    endtask

    task automatic test_clamp;
        int          cyc;
        int          mc;
        bit          tmo;
        logic [24:0] m;
        exp_t        e;
        model_run(16'h0F35, 16'h3C6F, 16'h1234, 5'd31, m, mc);
        start_run(16'h0F35, 16'h3C6F, 16'h1234, 5'd31, m, mc);
        wait_done(0, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL clamp_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if ($countones(out_mines) != 24) $display("FAIL clamp_count: got %0d want 24", $countones(out_mines)); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL clamp_mines: got %h want %h", out_mines, e.mines); else n_pass++;

        start_run(16'h0F35, 16'h3C6F, 16'h1234, 5'd0, 25'h0, 1);
        wait_done(0, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL zero_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL zero_mines: got %h want %h", out_mines, e.mines); else n_pass++;
    endtask

    task automatic test_start_while_busy;
        int          cyc;
        int          mc;
        bit          tmo;
        logic [24:0] m;
        exp_t        e;
        model_run(16'h6255, 16'h3619, 16'hACE1, 5'd5, m, mc);
        start_run(16'h6255, 16'h3619, 16'hACE1, 5'd5, m, mc);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (out_mines !== 25'h0000007) $display("FAIL busy_hold_mines: got %h want 0000007", out_mines); else n_pass++;
        mult      = 16'h0001;
        inc       = 16'h8000;
        seed      = 16'h0000;
        mines_num = 5'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL busy_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL busy_mines: got %h want %h", out_mines, e.mines); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (out_busy !== 1'b0) $display("FAIL busy_no_retrigger: got %b want 0", out_busy); else n_pass++;
    endtask

    task automatic test_random;
        int          cyc;
        int          mc;
        bit          tmo;
        logic [24:0] m;
        logic [15:0] a, c, s;
        logic [4:0]  n;
        exp_t        e;
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom);
            c = 16'($urandom);
            s = 16'($urandom);
            n = 5'($urandom_range(1, 24));
            model_run(a, c, s, n, m, mc);
            start_run(a, c, s, n, m, mc);
            wait_done(0, 1'b0, cyc, tmo);
            e = sb.pop_front();
            n_checks++; if (tmo || cyc != e.cycles) $display("FAIL rand%0d_latency: got %0d (timeout=%0b) want %0d", k, cyc, tmo, e.cycles); else n_pass++;
            n_checks++; if (out_mines !== e.mines) $display("FAIL rand%0d_mines: got %h want %h", k, out_mines, e.mines); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int          cyc;
        int          mc;
        bit          tmo;
        logic [24:0] m;
        exp_t        e;
        start_run(16'h0001, 16'h8000, 16'h0000, 5'd1, 25'h0001000, 3);
        wait_done(0, 1'b1, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL b2b_first_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL b2b_first_mines: got %h want %h", out_mines, e.mines); else n_pass++;
        seed = 16'h4000;
        model_run(16'h0001, 16'h8000, 16'h4000, 5'd1, m, mc);
        sb.push_back('{mines: m, cycles: mc + 1});
        wait_done(0, 1'b1, cyc, tmo);
        start = 1'b0;
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL b2b_second_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL b2b_second_mines: got %h want %h", out_mines, e.mines); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (out_busy !== 1'b0 || out_done !== 1'b0) $display("FAIL b2b_idle_after_release: got busy=%b done=%b want 0 0", out_busy, out_done); else n_pass++;
    endtask

`ifdef MINE_SAFE_CELL_EN
    task automatic test_safe_cell;
        int   cyc;
        bit   tmo;
        exp_t e;
        safe_cell = 5'd0;
        start_run(16'h0001, 16'h0000, 16'h0000, 5'd2, 25'h0000006, 8);
        wait_done(0, 1'b0, cyc, tmo);
        e = sb.pop_front();
        n_checks++; if (tmo || cyc != e.cycles) $display("FAIL safe_latency: got %0d (timeout=%0b) want %0d", cyc, tmo, e.cycles); else n_pass++;
        n_checks++; if (out_mines !== e.mines) $display("FAIL safe_mines: got %h want %h", out_mines, e.mines); else n_pass++;
        safe_cell = 5'd31;
    endtask
`endif

    initial begin
        test_reset();
        test_forced_collisions();
        test_index_mapping();
        test_clamp();
        test_forced_collisions();
        test_start_while_busy();
        test_random();
        test_back_to_back();
`ifdef MINE_SAFE_CELL_EN
        test_safe_cell();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mine_place_ctrl.md
Name: mine_place_ctrl

Overview:
- Sequencer that fills the 5x5 Minesweeper board with mines from a linear congruential generator (LCG).
- On a start pulse it steps the LCG X[n+1] = (a*X[n] + c) mod 2^16 once per draw and maps each value to a cell index.
- Collisions are resolved by linear probing, so every run terminates within a fixed number of cycles.
- The finished 25-bit mine map is presented to the board/game FSM with a one-cycle done strobe.

Parameters:
- GRID_CELLS, 25, number of board cells; also the out_mines width.
- LCG_W, 16, LCG state width; the modulus is fixed at 2^LCG_W.
- MAX_MINES, 24, upper clamp on the requested mine count; must be ≤ GRID_CELLS-1.

Ports:
- in_clka  input  1  clock, rising edge.
- in_rst_n  input  1  asynchronous reset, active low.
- in_start  input  1  single-cycle request to generate a new board.
- in_mult  input  LCG_W  multiplier a; sampled on accept.
- in_increment  input  LCG_W  increment c; sampled on accept.
- in_seed  input  LCG_W  X[0]; sampled on accept.
- in_mines_num  input  5  requested mine count; sampled on accept.
- out_mines  output  GRID_CELLS  mine map; bit i set means cell i holds a mine.
- out_busy  output  1  high while a generation run is in progress.
- out_done  output  1  one-cycle pulse when out_mines is valid.

Behaviour:
- Fixed decisions: one clock, in_clka. in_rst_n is asynchronous and active low.
- Reset values: all state clears immediately on reset, including mid-run.
  - State = IDLE, out_mines = 0, out_busy = 0, out_done = 0.
  - Internal map, count, X and the candidate index are all 0.
- States: IDLE, DRAW, PROBE, DONE.
- IDLE:
  - in_start=1 latches a, c, X = in_seed and target = min(in_mines_num, MAX_MINES).
  - It also clears the internal map and count.
  - If target = 0, go to DONE; otherwise go to DRAW.
- DRAW (1 cycle):
  - X <= a*X + c, truncated to LCG_W bits.
  - cand <= (X_next[15:8] * 25) >> 8. This is an 8x5-bit product taking bits [12:8], so cand is always 0..24.
  - Go to PROBE.
- PROBE:
  - If map[cand] = 0: set map[cand] and increment count.
    - If the new count equals target, go to DONE; otherwise go to DRAW.
  - If map[cand] = 1: cand <= (cand = 24) ? 0 : cand+1 and stay in PROBE.
- DONE (1 cycle):
  - out_mines <= internal map.
  - out_done = 1 and out_busy = 0 during this cycle.
  - Next state is IDLE.
- out_busy = 1 in DRAW and PROBE only.
- out_mines changes only on entry to DONE. It holds its value across IDLE and through the next run until that run's DONE.
- in_start outside IDLE is ignored. A start held high in IDLE re-triggers every run.
- Latency: for the i-th placement (0-based), DRAW plus PROBE takes 2 + p_i cycles, where p_i is the collision count. The worst case is bounded because target ≤ 24 < 25 cells.
- Arithmetic: all multiply/add results wrap modulo 2^LCG_W. No in_modulus input exists; the modulus is fixed.

Optional Feature:
- Macro: MINE_SAFE_CELL_EN.
- Defined:
  - Adds input in_safe_cell [4:0], sampled on accept.
  - PROBE treats cand = safe cell as occupied; that cell is never mined.
  - Values ≥ 25 disable the exclusion.
- Undefined:
  - The port is absent and all 25 cells are eligible.

Decomposition:
- Package mine_pkg holds:
  - GRID_CELLS, LCG_W and CELL_IDX_W = 5 constants.
  - The state enum (IDLE, DRAW, PROBE, DONE).
- Sub-module lcg_step (combinational):
  - Inputs x, a, c; outputs x_next and cell index.
  - Instantiated once by mine_place_ctrl and reusable by the bench's reference model.

Test Plan:
1. Reset mid-run:
   - Stimulus: assert in_rst_n=0 while in PROBE.
   - Response: out_busy, out_done and out_mines drop to 0 asynchronously (before the next edge); state returns to IDLE; a fresh start then runs normally.
2. Forced collisions:
   - Stimulus: a=1, c=0, seed=0, mines=3.
   - Response: cand is always 0, and probing yields out_mines=25'h0000007.
   - out_done asserts exactly 10 cycles after the accepting edge (9 DRAW/PROBE cycles plus DONE).
3. Index mapping:
   - Stimulus: a=1, c=16'h8000, seed=0, mines=1.
   - Response: X=16'h8000, cand=12, out_mines=25'h0001000, done at cycle 3.
4. Clamp:
   - Stimulus: mines=31, then mines=0.
   - Response: the first run gives exactly 24 bits set in out_mines; the second gives out_mines=0 with done one cycle after accept.
5. Start while busy:
   - Stimulus: a second in_start pulse issued during PROBE.
   - Response: it is ignored, and the result matches the lcg_step reference model for the first request.
6. Safe cell (MINE_SAFE_CELL_EN):
   - Stimulus: a=1, c=0, seed=0, safe=0, mines=2.
   - Response: out_mines=25'h0000006.
